// File: rtl/pc_return_stack.sv
// Program counter with call/return LIFO: turns control-unit strobes into the fetch address.
// Latency: a strobe in cycle N shows its new pc/sp in cycle N+1; a pushed entry can be popped in cycle N+1.
// No backpressure: one action per cycle, and lower-priority strobes in the same cycle are dropped.
module pc_return_stack #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 0,
    localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic              stall,
    input  logic              halt,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic [SP_W-1:0]   sp,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] RV   = ADDR_W'(RESET_VECTOR);
    localparam logic [SP_W-1:0]   FULL = SP_W'(STACK_DEPTH);
    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_UNDER = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              act_ret;
    logic              act_call;
    logic              push_en;

    // Resolve the strobe priority once so the FSM and the stack write agree.
    always_comb begin
        pc_inc   = pc + ADDR_W'(1);
        sp_dec   = sp - SP_W'(1);
        push_idx = sp[IDX_W-1:0];
        pop_idx  = sp_dec[IDX_W-1:0];
        act_ret  = (state == ST_RUN) && !stall && !halt && ret;
        act_call = (state == ST_RUN) && !stall && !halt && !ret && call;
        push_en  = act_call && (sp != FULL);
    end

    // Return-address storage; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[push_idx] <= pc_inc;
        end
    end

    // Control FSM with registered pc, sp and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= RV;
            sp         <= '0;
            running    <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stall) begin
                        // freeze everything for this cycle
                    end else if (halt) begin
                        state   <= ST_HALTED;
                        running <= 1'b0;
                    end else if (act_ret) begin
                        if (sp == '0) begin
                            state      <= ST_FAULT;
                            running    <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= CODE_UNDER;
                        end else begin
                            pc <= stack[pop_idx];
                            sp <= sp_dec;
                        end
                    end else if (act_call) begin
                        if (sp == FULL) begin
                            state      <= ST_FAULT;
                            running    <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= CODE_OVER;
                        end else begin
                            pc <= target;
                            sp <= sp + SP_W'(1);
                        end
                    end else if (branch) begin
                        pc <= target;
                    end else if (step) begin
                        pc <= pc_inc;
                    end
                end
                ST_HALTED: begin
                    // Restart begins a fresh program: empty stack, pc back to the vector.
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        pc      <= RV;
                        sp      <= '0;
                    end
                end
                ST_FAULT: begin
                    // Frozen until reset.
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
